bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
//   68030-side bus slave: terminates CPU cycles that hit a small local
//   register window. It is the responder counterpart to the 030->Amiga cycle
//   translator. Cycles are qualified by AS30/DS30/RW30/SIZ/FC, and the block
//   answers with 32-bit DSACK after WAIT_STATES clocks, a read data drive or a
//   byte-laned register write. It sits in the CPU-clock domain beside the
//   slow-bus translator. Decode must keep the two blocks disjoint.
// PARAMETERS
//   BASE         32'h00F8_0000  window base; match is A[31:4]==BASE[31:4] (16-byte window)
//   WAIT_STATES  1              CLKCPU cycles inserted between decode and DSACK (0..15)
//   ID_VALUE     32'h5446_3330  read-only contents of register 3 ("TF30")
// PORTS
//   CLKCPU    in   1   CPU clock; sole clock, all logic on posedge
//   RESET     in   1   synchronous, active-high reset
//   A         in   32  CPU address
//   FC        in   3   function code; 3'b111 (CPU space) is never claimed
//   SIZ       in   2   transfer size: 01 byte, 10 word, 11 3-byte, 00 long
//   AS30      in   1   address strobe, active low, asynchronous to CLKCPU
//   DS30      in   1   data strobe, active low, asynchronous to CLKCPU
//   RW30      in   1   1=read, 0=write
//   D_IN      in   32  CPU write data (D31..D0)
//   D_OUT     out  32  read data for the claimed register
//   D_OE      out  1   high = drive D_OUT onto the CPU data bus
//   DS30ACK   out  2   DSACK1/DSACK0, active low; 2'b00 = 32-bit port ack
//   HIT       out  1   high while a cycle is claimed (IDLE excluded); masks other responders
//   REG0..2   out  32  each; register contents exported to fabric
// BEHAVIOUR
//   Sync: AS30 and DS30 each pass through a 2-flop synchroniser, giving as_s and ds_s.
//     A, FC, SIZ, RW30 and D_IN are sampled only when the FSM uses them.
//   Reset: state=IDLE, DS30ACK=2'b11, D_OE=0, D_OUT=0, HIT=0, REG0..2=0,
//     synchroniser flops=1. RESET in any state forces these values on the next
//     edge, including mid-cycle; no write is performed.
//   FSM IDLE -> WAIT -> ACK -> HOLD -> IDLE:
//     IDLE: if as_s=0, ds_s=0, FC!=3'b111 and address matches, latch
//       sel=A[3:2], lane=A[1:0], SIZ and RW30, load cnt=WAIT_STATES, and go to
//       WAIT (go directly to ACK if WAIT_STATES==0). Otherwise stay in IDLE.
//     WAIT: cnt decrements each cycle. Go to ACK when cnt==1. If as_s=1, abort
//       to IDLE.
//     ACK: DS30ACK=2'b00. On a write, perform one register write this cycle
//       using the latched D_IN. Go to HOLD.
//     HOLD: keep DS30ACK=2'b00 until as_s=1, then go to IDLE. DS30ACK returns
//       to 2'b11 on the same edge.
//   Latency: DS30ACK falls 3+WAIT_STATES rising edges after the edge that
//     first samples AS30 and DS30 low.
//   Read: D_OE=1 from WAIT (or ACK) through HOLD when the latched RW=1.
//     D_OUT = REG[sel], where sel 3 returns ID_VALUE. D_OUT is full 32 bits;
//     the CPU picks the lanes.
//   Write byte enables: lane k (k=0 is D31..24) is enabled when
//     lane <= k < lane+n, with n=1,2,3,4 for SIZ 01,10,11,00. Enables are
//     clipped at k=3 and never wrap. Writes to sel 3 are dropped but still
//     acknowledged.
//   Abort: AS negating before ACK returns the FSM to IDLE with no write and no ack.
//   Back-to-back: a new cycle is accepted only from IDLE. The CPU must have
//     negated AS first.
// TESTING
//   Long write to BASE+0, D_IN=32'hDEADBEEF, WAIT_STATES=1 -> REG0=DEADBEEF; DS30ACK=00 exactly 4 edges after sync sees AS low; released after AS high.
//   Byte write to BASE+5 (SIZ=01), D_IN=32'h00AA0000 -> only REG1[23:16]=AA; the other REG1 bytes are unchanged.
//   3-byte write to BASE+0xB (SIZ=11) -> only REG2[7:0] is written (lane clipped); long read of BASE+0xC -> D_OUT=5446_3330, D_OE=1.
//   FC=111 or address BASE+0x10 -> no ack, HIT=0, D_OE=0, registers unchanged.
//   AS negated during WAIT (WAIT_STATES=4) -> FSM returns to IDLE, no write, DS30ACK stays 11.
//   RESET pulsed during HOLD of a read -> next edge DS30ACK=11, D_OE=0, REG0..2=0.

Source files
------------

// File: rtl/bus_responder.sv
// 68030 bus slave for a 16-byte local register window: synchronises AS/DS,
// inserts WAIT_STATES clocks, then answers with a 32-bit DSACK and read data or a byte-laned write.
`timescale 1ns/1ps
module bus_responder #(
    parameter logic [31:0] BASE        = 32'h00F8_0000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5446_3330
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [2:0]  FC,
    input  logic [1:0]  SIZ,
    input  logic        AS30,
    input  logic        DS30,
    input  logic        RW30,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    output logic [1:0]  DS30ACK,
    output logic        HIT,
    output logic [31:0] REG0,
    output logic [31:0] REG1,
    output logic [31:0] REG2
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q;
    logic        as_m_q, as_s_q, ds_m_q, ds_s_q;
    logic [3:0]  cnt_q;
    logic [1:0]  sel_q, lane_q, siz_q;
    logic        rw_q;
    logic [31:0] din_q;
    logic [31:0] reg0_q, reg1_q, reg2_q;
    logic [31:0] d_out_q;
    logic        d_oe_q, hit_q;
    logic [1:0]  ack_q;

    logic        claim_d;
    logic [1:0]  rd_sel_d;
    logic [31:0] rd_data_d;
    logic [2:0]  n_bytes_d, lane_end_d;
    logic [3:0]  be_d;

    // Byte lane k covers D[31-8k -: 8]; lane 0 is the most significant byte.
    function automatic logic [31:0] wr_merge(input logic [31:0] old,
                                             input logic [31:0] din,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[31-8*k -: 8] = din[31-8*k -: 8];
        end
        return r;
    endfunction

    always_comb begin
        claim_d    = !as_s_q && !ds_s_q && (FC != 3'b111) && (A[31:4] == BASE[31:4]);
        // In IDLE the select is not latched yet, so read data comes straight from A.
        rd_sel_d   = (state_q == S_IDLE) ? A[3:2] : sel_q;
        case (rd_sel_d)
            2'd0:    rd_data_d = reg0_q;
            2'd1:    rd_data_d = reg1_q;
            2'd2:    rd_data_d = reg2_q;
            default: rd_data_d = ID_VALUE;
        endcase
        n_bytes_d  = (siz_q == 2'b00) ? 3'd4 : {1'b0, siz_q};
        lane_end_d = {1'b0, lane_q} + n_bytes_d;
        for (int k = 0; k < 4; k++) begin
            be_d[k] = (3'(k) >= {1'b0, lane_q}) && (3'(k) < lane_end_d);
        end
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q <= S_IDLE;
            as_m_q  <= 1'b1;
            as_s_q  <= 1'b1;
            ds_m_q  <= 1'b1;
            ds_s_q  <= 1'b1;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            lane_q  <= 2'd0;
            siz_q   <= 2'd0;
            rw_q    <= 1'b1;
            din_q   <= 32'd0;
            reg0_q  <= 32'd0;
            reg1_q  <= 32'd0;
            reg2_q  <= 32'd0;
            d_out_q <= 32'd0;
            d_oe_q  <= 1'b0;
            hit_q   <= 1'b0;
            ack_q   <= 2'b11;
        end else begin
            as_m_q <= AS30;
            as_s_q <= as_m_q;
            ds_m_q <= DS30;
            ds_s_q <= ds_m_q;
            case (state_q)
                S_IDLE: begin
                    if (claim_d) begin
                        sel_q   <= A[3:2];
                        lane_q  <= A[1:0];
                        siz_q   <= SIZ;
                        rw_q    <= RW30;
                        din_q   <= D_IN;
                        cnt_q   <= WS;
                        hit_q   <= 1'b1;
                        d_oe_q  <= RW30;
                        d_out_q <= rd_data_d;
                        state_q <= (WS == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    d_out_q <= rd_data_d;
                    if (as_s_q) begin
                        state_q <= S_IDLE;
                        hit_q   <= 1'b0;
                        d_oe_q  <= 1'b0;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    ack_q   <= 2'b00;
                    d_out_q <= rd_data_d;
                    state_q <= S_HOLD;
                    // Register 3 is the read-only ID; writes to it are acknowledged and dropped.
                    if (!rw_q) begin
                        case (sel_q)
                            2'd0:    reg0_q <= wr_merge(reg0_q, din_q, be_d);
                            2'd1:    reg1_q <= wr_merge(reg1_q, din_q, be_d);
                            2'd2:    reg2_q <= wr_merge(reg2_q, din_q, be_d);
                            default: ;
                        endcase
                    end
                end
                S_HOLD: begin
                    d_out_q <= rd_data_d;
                    if (as_s_q) begin
                        state_q <= S_IDLE;
                        ack_q   <= 2'b11;
                        hit_q   <= 1'b0;
                        d_oe_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign D_OUT   = d_out_q;
    assign D_OE    = d_oe_q;
    assign DS30ACK = ack_q;
    assign HIT     = hit_q;
    assign REG0    = reg0_q;
    assign REG1    = reg1_q;
    assign REG2    = reg2_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: one instance with WAIT_STATES=1 for the main traffic,
// a second with WAIT_STATES=4 for long-latency and abort cases.
`timescale 1ns/1ps
module tb_bus_responder;

    localparam logic [31:0] BASE = 32'h00F8_0000;
    localparam logic [31:0] IDV  = 32'h5446_3330;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, din;
    logic [2:0]  fc;
    logic [1:0]  siz;
    logic        as_n, as4_n, ds_n, rw;

    logic [31:0] dout, r0, r1, r2;
    logic        oe, hit;
    logic [1:0]  ack;
    logic [31:0] dout4, r0_4, r1_4, r2_4;
    logic        oe4, hit4;
    logic [1:0]  ack4;

    bus_responder #(.BASE(BASE), .WAIT_STATES(1), .ID_VALUE(IDV)) dut (
        .CLKCPU(clk), .RESET(rst), .A(a), .FC(fc), .SIZ(siz), .AS30(as_n), .DS30(ds_n),
        .RW30(rw), .D_IN(din), .D_OUT(dout), .D_OE(oe), .DS30ACK(ack), .HIT(hit),
        .REG0(r0), .REG1(r1), .REG2(r2)
    );

    bus_responder #(.BASE(BASE), .WAIT_STATES(4), .ID_VALUE(IDV)) dut4 (
        .CLKCPU(clk), .RESET(rst), .A(a), .FC(fc), .SIZ(siz), .AS30(as4_n), .DS30(ds_n),
        .RW30(rw), .D_IN(din), .D_OUT(dout4), .D_OE(oe4), .DS30ACK(ack4), .HIT(hit4),
        .REG0(r0_4), .REG1(r1_4), .REG2(r2_4)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mreg[3];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "/sb_underflow"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "/", e.tag}, got, e.val);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [1:0] sz);
        logic [31:0] r;
        int          n;
        n = (sz == 2'b00) ? 4 : int'(sz);
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(lane) && k < int'(lane) + n) r[31-8*k -: 8] = d[31-8*k -: 8];
        end
        return r;
    endfunction

    task automatic wait_ack(output int n);
        n = 0;
        #1;
        while (ack !== 2'b00 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_cycle(input logic [31:0] addr, input logic [2:0] f, input logic [1:0] sz,
                            input logic r, input logic [31:0] d);
        bit          claim;
        logic [1:0]  sel;
        logic [1:0]  ack_and;
        int          n;
        claim = (f != 3'b111) && (addr[31:4] == BASE[31:4]);
        sel   = addr[3:2];
        if (claim) begin
            push("lat", 32'd4);
            if (r) push("rdata", (sel == 2'd3) ? IDV : mreg[sel]);
            else if (sel != 2'd3) mreg[sel] = merge(mreg[sel], d, addr[1:0], sz);
        end else begin
            push("noack", 32'h3);
        end
        push("reg0", mreg[0]);
        push("reg1", mreg[1]);
        push("reg2", mreg[2]);

        @(negedge clk);
        a = addr; fc = f; siz = sz; rw = r; din = d; as_n = 1'b0; ds_n = 1'b0;
        @(posedge clk);
        if (claim) begin
            wait_ack(n);
            pop_chk("lat", 32'(n));
            chk("hit_claimed", 32'(hit), 32'd1);
            chk("oe_claimed", 32'(oe), 32'(r));
            if (r) pop_chk("rdata", dout);
        end else begin
            ack_and = 2'b11;
            repeat (10) begin
                #1;
                ack_and &= ack;
                chk("hit_unclaimed", 32'(hit | oe), 32'd0);
                @(posedge clk);
            end
            pop_chk("noack", 32'(ack_and));
        end

        @(negedge clk);
        as_n = 1'b1; ds_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (claim) chk("ack_hold", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        chk("ack_release", 32'(ack), 32'h3);
        chk("idle_hit_oe", 32'({hit, oe}), 32'd0);
        pop_chk("reg0", r0);
        pop_chk("reg1", r1);
        pop_chk("reg2", r2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] ack_and;
        rst = 1'b1; as_n = 1'b1; as4_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
        a = 32'd0; fc = 3'd5; siz = 2'd0; din = 32'd0;
        for (int i = 0; i < 3; i++) mreg[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'h3);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_reg0", r0, 32'd0);
        chk("rst_reg1", r1, 32'd0);
        chk("rst_reg2", r2, 32'd0);

        do_cycle(BASE + 32'h0, 3'd5, 2'b00, 1'b0, 32'hDEAD_BEEF);
        chk("long_write_reg0", r0, 32'hDEAD_BEEF);
        do_cycle(BASE + 32'h4, 3'd5, 2'b00, 1'b0, 32'h1122_3344);
        do_cycle(BASE + 32'h5, 3'd5, 2'b01, 1'b0, 32'h00AA_0000);
        chk("byte_write_reg1", r1, 32'h11AA_3344);
        do_cycle(BASE + 32'h8, 3'd1, 2'b00, 1'b0, 32'h5566_7788);
        do_cycle(BASE + 32'hB, 3'd1, 2'b11, 1'b0, 32'hCAFE_BABE);
        chk("3byte_clip_reg2", r2, 32'h5566_77BE);
        do_cycle(BASE + 32'hC, 3'd5, 2'b00, 1'b1, 32'h0);
        do_cycle(BASE + 32'h2, 3'd5, 2'b10, 1'b0, 32'h0000_1234);
        chk("word_write_reg0", r0, 32'hDEAD_1234);
        do_cycle(BASE + 32'hC, 3'd5, 2'b00, 1'b0, 32'hFFFF_FFFF);
        do_cycle(BASE + 32'h0, 3'd5, 2'b00, 1'b1, 32'h0);
        do_cycle(BASE + 32'h0, 3'b111, 2'b00, 1'b0, 32'h0BAD_0BAD);
        do_cycle(BASE + 32'h10, 3'd5, 2'b00, 1'b0, 32'h0BAD_0BAD);

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  off;
            logic [31:0] rd;
            off = 4'($urandom_range(0, 15));
            rd  = $urandom;
            do_cycle(BASE | {28'd0, off}, 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), rd);
        end

        // Long-latency instance: full write, then an aborted write.
        @(negedge clk);
        a = BASE + 32'h4; fc = 3'd5; siz = 2'b00; rw = 1'b0; din = 32'h0BAD_F00D;
        as4_n = 1'b0; ds_n = 1'b0;
        @(posedge clk);
        n = 0;
        #1;
        while (ack4 !== 2'b00 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ws4_latency", 32'(n), 32'd7);
        @(negedge clk);
        as4_n = 1'b1; ds_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ws4_release", 32'(ack4), 32'h3);
        chk("ws4_reg1", r1_4, 32'h0BAD_F00D);

        @(negedge clk);
        a = BASE; fc = 3'd5; siz = 2'b00; rw = 1'b0; din = 32'h1234_5678;
        as4_n = 1'b0; ds_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_hit_in_wait", 32'(hit4), 32'd1);
        @(negedge clk);
        as4_n = 1'b1; ds_n = 1'b1;
        ack_and = 2'b11;
        repeat (12) begin
            @(posedge clk);
            #1;
            ack_and &= ack4;
        end
        chk("abort_no_ack", 32'(ack_and), 32'h3);
        chk("abort_hit", 32'(hit4), 32'd0);
        chk("abort_reg0", r0_4, 32'd0);

        // Reset asserted while a read is held in HOLD.
        @(negedge clk);
        a = BASE + 32'h4; fc = 3'd5; siz = 2'b00; rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        @(posedge clk);
        wait_ack(n);
        chk("rst_hold_lat", 32'(n), 32'd4);
        chk("rst_hold_oe_before", 32'(oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_ack", 32'(ack), 32'h3);
        chk("rst_hold_oe", 32'(oe), 32'd0);
        chk("rst_hold_hit", 32'(hit), 32'd0);
        chk("rst_hold_reg0", r0, 32'd0);
        chk("rst_hold_reg1", r1, 32'd0);
        chk("rst_hold_reg2", r2, 32'd0);
        @(negedge clk);
        rst = 1'b0; as_n = 1'b1; ds_n = 1'b1;
        for (int i = 0; i < 3; i++) mreg[i] = 32'd0;
        repeat (3) @(posedge clk);

        do_cycle(BASE + 32'h8, 3'd5, 2'b00, 1'b0, 32'h0102_0304);
        do_cycle(BASE + 32'h8, 3'd5, 2'b00, 1'b1, 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
